pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Central sequencer for the 5-stage pipeline's freeze/flush controls; replaces the ad-hoc freeze/flush drives at the IF/ID stages.
- Merges three stall/flush sources into one set of per-stage controls with fixed priority:
  - load-use hazard from the hazard unit;
  - taken branch from EXE;
  - multi-cycle memory access from the SRAM interface.
- Holds stall/flush performance counters and a sticky memory-timeout error.

Parameters:
- MEM_TIMEOUT, 64, MEM_WAIT cycles before declaring a timeout (>=2).
- CNT_W, 16, width of each performance counter (saturating).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- hazard  in  1  load-use hazard from the hazard detection unit (ID stage).
- Branch_taken  in  1  taken-branch indication from the EXE stage.
- mem_req  in  1  MEM stage holds a load/store (MEM_R_EN | MEM_W_EN).
- mem_ready  in  1  SRAM interface completes the access this cycle.
- freeze_if  out  1  hold PC and IF_Stage_Reg.
- flush_if  out  1  clear IF_Stage_Reg to a bubble.
- flush_id  out  1  clear ID_Stage_Reg to a bubble (WB_EN, MEM_R_EN, MEM_W_EN, B = 0).
- freeze_all  out  1  hold every pipeline register, including EXE/MEM/WB.
- mem_err  out  1  sticky memory-timeout error.
- hazard_stalls  out  CNT_W  cycles stalled by hazard.
- mem_stalls  out  CNT_W  cycles frozen by memory wait.
- branch_flushes  out  CNT_W  number of taken-branch flushes.

Behaviour:
- Control outputs are Mealy, combinational from the current state and inputs, zero latency. The pipeline must see freeze/flush in the same cycle as the cause.
- State register (2 bits), one of:
  - RUN
  - MEM_WAIT
  - ERR
- Reset (rst=1 at a clock edge):
  - state <= RUN, all counters <= 0, mem_err <= 0.
  - While rst is high, all control outputs are forced to 0.
- Reset mid-MEM_WAIT or in ERR returns to RUN on that same edge.
- RUN, evaluated in priority order:
  1. mem_req & !mem_ready:
     - freeze_all=1, freeze_if=1, flush_if=0, flush_id=0.
     - Next state MEM_WAIT; wait counter <= 1.
     - Branch and hazard are masked this cycle. The EXE/ID regs are frozen, so those inputs persist and are serviced after release.
  2. Branch_taken:
     - flush_if=1, flush_id=1, freeze_if=0.
     - The PC loads BranchAddr in the IF stage.
     - branch_flushes++.
     - Takes priority over hazard: the hazarding instruction is squashed.
  3. hazard:
     - freeze_if=1, flush_id=1 (bubble inserted).
     - hazard_stalls++.
  4. Otherwise all controls are 0.
  - mem_req & mem_ready: single-cycle access, no freeze, stays in RUN; rules 2-4 apply.
- MEM_WAIT:
  - freeze_all=1, freeze_if=1, flushes 0.
  - mem_stalls++ every cycle in this state.
  - mem_ready=1: freeze still asserted this cycle, next state RUN.
  - !mem_ready and wait counter == MEM_TIMEOUT-1: next state ERR, mem_err <= 1.
  - Otherwise the wait counter increments.
  - mem_req dropping while in MEM_WAIT is treated as mem_ready (protocol violation guard).
- ERR:
  - freeze_all=1, freeze_if=1, mem_err=1.
  - Stays in ERR until rst.
  - No counters advance.
- Counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - Increment only in the cycle the corresponding action is driven.
- Wait counter:
  - Internal, width clog2(MEM_TIMEOUT)+1.
  - Cleared on entry to RUN.
- Invariants:
  - flush_if and freeze_if are never both 1.
  - freeze_all=1 implies flush_id=0 and flush_if=0.

Decomposition:
- Shared package pipe_pkg:
  - state encoding constants ST_RUN=2'd0, ST_MEM_WAIT=2'd1, ST_ERR=2'd2;
  - default MEM_TIMEOUT.
- One sub-module, sat_counter (parameter W; inputs clk, rst, inc; output count), instantiated three times for the performance counters.
- The FSM and output decode stay in pipe_ctrl.

Test Plan:
- Reset, no activity:
  - Stimulus: rst high 2 cycles, then idle 5 cycles.
  - Expected: all controls 0; counters 0; state RUN.
- Hazard stall:
  - Stimulus: hazard=1 for 2 cycles.
  - Expected: freeze_if=1 and flush_id=1 in both cycles; hazard_stalls=2; PC_Reg constant across them.
- Branch vs hazard:
  - Stimulus: hazard=1 and Branch_taken=1 in the same cycle.
  - Expected: flush_if=1, flush_id=1, freeze_if=0; branch_flushes=1; hazard_stalls unchanged.
- Memory wait:
  - Stimulus: mem_req=1 with mem_ready low for 3 cycles, then high.
  - Expected: freeze_all=1 for 4 cycles; mem_stalls=3; back in RUN; a Branch_taken held throughout is serviced in the first RUN cycle.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, mem_req=1, mem_ready=0 indefinitely.
  - Expected: mem_err=1 after cycle 4 of wait; freeze_all stays 1; rst clears to RUN with mem_err=0.
- Saturation:
  - Stimulus: CNT_W=2, hazard held for 6 cycles.
  - Expected: hazard_stalls reaches 3 and stays at 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline freeze/flush sequencer: state encoding
// and the default memory-wait timeout.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } pipe_state_t;

  localparam int DEF_MEM_TIMEOUT = 64;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones instead of
// wrapping, cleared by synchronous active-high rst.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc)
      count <= sat_inc(count);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central freeze/flush sequencer for the 5-stage pipeline: merges memory wait,
// taken branch and load-use hazard into per-stage controls, with perf counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             Branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_if,
  output logic             flush_if,
  output logic             flush_id,
  output logic             freeze_all,
  output logic             mem_err,
  output logic [CNT_W-1:0] hazard_stalls,
  output logic [CNT_W-1:0] mem_stalls,
  output logic [CNT_W-1:0] branch_flushes
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

  pipe_state_t       state_q, state_nxt;
  logic [WAIT_W-1:0] wait_q, wait_nxt;
  logic              err_set;
  logic              hz_inc, mem_inc, br_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      mem_err <= 1'b0;
    end else begin
      state_q <= state_nxt;
      wait_q  <= wait_nxt;
      if (err_set)
        mem_err <= 1'b1;
    end
  end

  // Mealy decode: the pipeline sees freeze/flush in the same cycle as the cause.
  always_comb begin
    state_nxt  = state_q;
    wait_nxt   = wait_q;
    err_set    = 1'b0;
    freeze_if  = 1'b0;
    flush_if   = 1'b0;
    flush_id   = 1'b0;
    freeze_all = 1'b0;
    hz_inc     = 1'b0;
    mem_inc    = 1'b0;
    br_inc     = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            // EXE/ID are frozen, so a pending branch or hazard is serviced after release.
            freeze_all = 1'b1;
            freeze_if  = 1'b1;
            state_nxt  = ST_MEM_WAIT;
            wait_nxt   = WAIT_W'(1);
          end else if (Branch_taken) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
            br_inc   = 1'b1;
          end else if (hazard) begin
            freeze_if = 1'b1;
            flush_id  = 1'b1;
            hz_inc    = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          freeze_all = 1'b1;
          freeze_if  = 1'b1;
          mem_inc    = 1'b1;
          // A dropped request is released like a completed access.
          if (mem_ready || !mem_req) begin
            state_nxt = ST_RUN;
            wait_nxt  = '0;
          end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state_nxt = ST_ERR;
            err_set   = 1'b1;
          end else begin
            wait_nxt = wait_q + WAIT_W'(1);
          end
        end
        ST_ERR: begin
          freeze_all = 1'b1;
          freeze_if  = 1'b1;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_hazard_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hz_inc),
    .count (hazard_stalls)
  );

  sat_counter #(.W(CNT_W)) u_mem_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mem_inc),
    .count (mem_stalls)
  );

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (br_inc),
    .count (branch_flushes)
  );

endmodule
